// File: rtl/soundrive_i2s_tx.sv
// Soundrive/Covox back end: mixes four offset-binary DAC channels to stereo and
// serialises them as 16-bit I2S (master, BCLK/LRCK generated locally from clk28).
module soundrive_i2s_tx #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] ch_l0,
  input  logic [7:0] ch_l1,
  input  logic [7:0] ch_r0,
  input  logic [7:0] ch_r1,
  output logic       i2s_bclk,
  output logic       i2s_lrck,
  output logic       i2s_sdata,
  output logic       sample_stb
);

  localparam logic [7:0] DivLast = 8'(BCLK_DIV - 1);

  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        bclk_q, bclk_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] word_l_q, word_l_d;
  logic [15:0] word_r_q, word_r_d;
  logic        lrck_q, lrck_d;
  logic        sdata_q, sdata_d;
  logic        stb_q, stb_d;

  logic        div_wrap;
  logic        fall;
  logic        capture;
  logic [5:0]  bit_nxt;
  logic [3:0]  bit_idx;
  logic        in_slot;
  logic [8:0]  sum_l, sum_r;
  logic [15:0] mix_l, mix_r;

  // Offset-binary sum minus 256 is just an MSB flip of the 9-bit sum.
  always_comb begin
    sum_l = {1'b0, ch_l0} + {1'b0, ch_l1};
    sum_r = {1'b0, ch_r0} + {1'b0, ch_r1};
    mix_l = {~sum_l[8], sum_l[7:0], 7'b0};
    mix_r = {~sum_r[8], sum_r[7:0], 7'b0};
  end

  always_comb begin
    div_wrap = (div_cnt_q == DivLast);
    fall     = div_wrap & bclk_q;
    capture  = fall & (bit_cnt_q == 6'd63);
    bit_nxt  = bit_cnt_q + 6'd1;
    // Both slots use bit (16 - n) mod 16 of their word, i.e. the negated low nibble.
    bit_idx  = ~bit_nxt[3:0] + 4'd1;
    in_slot  = (bit_nxt[4:0] != 5'd0) && (bit_nxt[4:0] <= 5'd16);

    div_cnt_d = div_wrap ? 8'd0 : div_cnt_q + 8'd1;
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    word_l_d  = word_l_q;
    word_r_d  = word_r_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    stb_d     = capture;

    if (capture) begin
      word_l_d = en ? mix_l : 16'h0000;
      word_r_d = en ? mix_r : 16'h0000;
    end

    if (fall) begin
      bit_cnt_d = bit_nxt;
      lrck_d    = bit_nxt[5];
      if (!in_slot) begin
        sdata_d = 1'b0;
      end else if (bit_nxt[5]) begin
        sdata_d = word_r_q[bit_idx];
      end else begin
        sdata_d = word_l_q[bit_idx];
      end
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      div_cnt_q <= 8'd0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= 6'd63;
      word_l_q  <= 16'h0000;
      word_r_q  <= 16'h0000;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      word_l_q  <= word_l_d;
      word_r_q  <= word_r_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      stb_q     <= stb_d;
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrck   = lrck_q;
  assign i2s_sdata  = sdata_q;
  assign sample_stb = stb_q;

endmodule

// File: tb/tb_soundrive_i2s_tx.sv
// Bench for soundrive_i2s_tx: a frame-level reference model queues expected stereo words at each
// capture instant; a monitor deserialises the I2S stream like a DAC and compares.
module tb_soundrive_i2s_tx;

  localparam int unsigned Div   = 4;
  localparam int unsigned First = 2 * Div;
  localparam int unsigned Frame = 128 * Div;

  logic       clk28 = 1'b0;
  logic       rst   = 1'b1;
  logic       en    = 1'b1;
  logic [7:0] ch_l0 = 8'h80;
  logic [7:0] ch_l1 = 8'h80;
  logic [7:0] ch_r0 = 8'h80;
  logic [7:0] ch_r1 = 8'h80;
  logic       i2s_bclk, i2s_lrck, i2s_sdata, sample_stb;

  soundrive_i2s_tx #(.BCLK_DIV(Div)) dut (
    .clk28      (clk28),
    .rst        (rst),
    .en         (en),
    .ch_l0      (ch_l0),
    .ch_l1      (ch_l1),
    .ch_r0      (ch_r0),
    .ch_r1      (ch_r1),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_sdata  (i2s_sdata),
    .sample_stb (sample_stb)
  );

  always #5 clk28 = ~clk28;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;

  frame_t      exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          frames_checked = 0;
  int unsigned edge_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Word = (a-128 + b-128) * 128 as 16-bit two's complement; silence when disabled.
  function automatic logic [15:0] ref_word(input logic [7:0] a, input logic [7:0] b,
                                           input logic on);
    int v;
    v = ((int'(a) - 128) + (int'(b) - 128)) * 128;
    return on ? 16'(v) : 16'h0000;
  endfunction

  function automatic bit is_capture_edge(input int unsigned n);
    return (n >= First) && (((n - First) % Frame) == 0);
  endfunction

  // Reference model: counts clk28 edges since reset release; captures at 2*Div + k*Frame.
  always @(posedge clk28) begin
    if (rst) begin
      edge_n = 0;
      exp_q.delete();
    end else begin
      edge_n++;
      if (is_capture_edge(edge_n)) begin
        exp_q.push_back({ref_word(ch_l0, ch_l1, en), ref_word(ch_r0, ch_r1, en)});
      end
    end
  end

  // Monitor: sample away from the active edge, rebuild slots from BCLK rises.
  logic        prev_bclk = 1'b0;
  bit          in_frame = 0;
  bit          have_fall = 0;
  int          pos = 0;
  int          since_fall = 0;
  logic [15:0] got_l, got_r;
  bit          extra_bits, lrck_bad;
  frame_t      e;

  always @(negedge clk28) begin
    if (rst) begin
      in_frame   = 0;
      have_fall  = 0;
      prev_bclk  = 1'b0;
      since_fall = 0;
    end else begin
      check("sample_stb", 32'(sample_stb), 32'(is_capture_edge(edge_n)));
      since_fall++;
      if (prev_bclk && !i2s_bclk) begin
        if (have_fall) check("bclk_period", 32'(since_fall), 32'(2 * Div));
        have_fall  = 1;
        since_fall = 0;
        if (sample_stb) begin
          in_frame   = 1;
          pos        = 0;
          got_l      = '0;
          got_r      = '0;
          extra_bits = 0;
          lrck_bad   = 0;
        end else if (in_frame) begin
          pos++;
        end
        if (in_frame && (i2s_lrck !== (pos >= 32))) lrck_bad = 1;
      end else if (!prev_bclk && i2s_bclk && in_frame) begin
        if (pos >= 1 && pos <= 16) got_l[16-pos] = i2s_sdata;
        else if (pos >= 33 && pos <= 48) got_r[48-pos] = i2s_sdata;
        else if (i2s_sdata !== 1'b0) extra_bits = 1;
        if (pos == 63) begin
          if (exp_q.size() == 0) begin
            check("frame_queue_empty", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("left_word", 32'(got_l), 32'(e.l));
            check("right_word", 32'(got_r), 32'(e.r));
            check("idle_bits_zero", 32'(extra_bits), 32'd0);
            check("lrck_framing", 32'(lrck_bad), 32'd0);
            frames_checked++;
          end
          in_frame = 0;
        end
      end
      prev_bclk = i2s_bclk;
    end
  end

  task automatic run_frames(input int n);
    repeat (n * Frame) @(negedge clk28);
  endtask

  task automatic wait_stb();
    int n = 0;
    @(negedge clk28);
    while (!sample_stb && n < 2 * Frame) begin
      @(negedge clk28);
      n++;
    end
    if (!sample_stb) check("stb_timeout", 32'(sample_stb), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk28);
    rst = 1'b0;

    // Silence from reset.
    run_frames(3);

    // Full-scale left, negative full-scale right.
    ch_l0 = 8'hFF; ch_l1 = 8'hFF; ch_r0 = 8'h00; ch_r1 = 8'h00;
    run_frames(2);

    // One LSB either side of zero.
    ch_l0 = 8'h81; ch_l1 = 8'h80; ch_r0 = 8'h7F; ch_r1 = 8'h80;
    run_frames(2);

    // Change right channel in the middle of the left slot: no tearing.
    ch_l0 = 8'h80; ch_l1 = 8'h80; ch_r0 = 8'h80; ch_r1 = 8'h80;
    wait_stb();
    wait_stb();
    repeat (8 * 2 * Div) @(negedge clk28);
    ch_r0 = 8'hC0;
    run_frames(2);

    // Disabled with live channels, then re-enabled.
    en = 1'b0;
    ch_l0 = 8'($urandom); ch_l1 = 8'($urandom); ch_r0 = 8'($urandom); ch_r1 = 8'($urandom);
    run_frames(2);
    en = 1'b1;
    run_frames(2);

    // Random channel/enable changes at random points in the frame.
    for (int i = 0; i < 8; i++) begin
      ch_l0 = 8'($urandom); ch_l1 = 8'($urandom);
      ch_r0 = 8'($urandom); ch_r1 = 8'($urandom);
      en    = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(200, 700)) @(negedge clk28);
    end
    en = 1'b1;

    // Reset at bit_cnt 40 (mid right slot): outputs drop at once, frame abandoned.
    ch_l0 = 8'hA5; ch_l1 = 8'h3C; ch_r0 = 8'h11; ch_r1 = 8'hF0;
    wait_stb();
    repeat (40 * 2 * Div) @(negedge clk28);
    @(posedge clk28);
    #1 rst = 1'b1;
    #1;
    check("rst_bclk", 32'(i2s_bclk), 32'd0);
    check("rst_lrck", 32'(i2s_lrck), 32'd0);
    check("rst_sdata", 32'(i2s_sdata), 32'd0);
    check("rst_stb", 32'(sample_stb), 32'd0);
    repeat (2) @(negedge clk28);
    rst = 1'b0;
    ch_l0 = 8'h10; ch_l1 = 8'hE3; ch_r0 = 8'hC8; ch_r1 = 8'h44;
    run_frames(4);

    check("frames_seen_min", 32'(frames_checked >= 15), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soundrive_i2s_tx.md
Name: soundrive_i2s_tx

Overview:
- Back end of the Soundrive/Covox path. Takes the four 8-bit offset-binary DAC channel registers written by the CPU-side capture block and mixes them to stereo.
- Serialises the mix as 16-bit two's-complement I2S to an external audio DAC.
- Runs in the clk28 domain. Generates BCLK, LRCK and SDATA itself as the I2S master.

Parameters:
- BCLK_DIV, 4: BCLK half-period in clk28 cycles. Legal range is 2..255. The default gives BCLK = 3.5 MHz and fs = 28 MHz / 512 = 54.6875 kHz.

Ports:
- clk28  in  1  system clock, 28 MHz
- rst  in  1  asynchronous reset, active-high
- en  in  1  output enable; 0 sends silence
- ch_l0  in  8  left channel A, offset-binary (0x80 is zero)
- ch_l1  in  8  left channel B, offset-binary
- ch_r0  in  8  right channel A, offset-binary
- ch_r1  in  8  right channel B, offset-binary
- i2s_bclk  out  1  bit clock
- i2s_lrck  out  1  word select; 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first
- sample_stb  out  1  one clk28 pulse when a new stereo sample is latched

Behaviour:
- Reset values (rst=1, async): i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, sample_stb=0, div_cnt=0, bit_cnt=63, both sample words 0.
  - Reset asserted mid-frame forces these values immediately. The frame is abandoned.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 on every clk28 edge.
  - At BCLK_DIV-1 it wraps to 0 and i2s_bclk toggles.
  - BCLK period = 2*BCLK_DIV clk28 cycles.
  - "Fall event" = the clk28 cycle in which i2s_bclk is toggled from 1 to 0.
- Bit counter: 6-bit bit_cnt increments modulo 64 on each fall event. All serial outputs update only on fall events, registered in the same clk28 cycle as the i2s_bclk fall.
- Mix (combinational from inputs):
  - L9 = (ch_l0 - 128) + (ch_l1 - 128), signed 9-bit, range -256..+254. R9 is formed the same way from ch_r0 and ch_r1.
  - Word = L9 sign-extended and shifted left by 7, 16-bit.
  - Word range is 0x8000..0x7F00. No saturation is needed.
- Capture:
  - On the fall event where bit_cnt wraps 63 to 0, both left and right words are latched simultaneously.
  - If en=0 at that cycle, both latched words are 0.
  - sample_stb=1 in exactly that clk28 cycle and 0 otherwise.
  - Channel or en changes mid-frame take effect only at the next capture. There is no tearing between L and R.
- Framing (bit_cnt value after the fall event):
  - i2s_lrck = 1 for bit_cnt 32..63 and 0 for 0..31.
  - i2s_sdata = left word bit 16-bit_cnt for bit_cnt 1..16.
  - i2s_sdata = right word bit 48-bit_cnt for bit_cnt 33..48.
  - i2s_sdata = 0 for all other bit_cnt values.
  - This is standard I2S: MSB one BCLK after the LRCK edge, DAC samples on the BCLK rise.
- The first fall event after reset release occurs at clk28 cycle 2*BCLK_DIV. That event is the first capture, with bit_cnt=0.
- Frame length: 64 BCLK = 128*BCLK_DIV clk28 cycles (512 at default).
- BCLK and LRCK run continuously regardless of en.

Test Plan:
- Reset release with all channels at 0x80 and en=1:
  - first sample_stb 8 clk28 cycles after reset release, then every 512;
  - i2s_bclk period 8;
  - i2s_lrck high for 32 BCLK, low for 32;
  - i2s_sdata constantly 0.
- ch_l0=ch_l1=0xFF, ch_r0=ch_r1=0x00, en=1 -> left slot 0x7F00 and right slot 0x8000, MSB first starting one BCLK after each i2s_lrck edge, remaining 16 bits of each slot 0.
- ch_l0=0x81, ch_l1=0x80, ch_r0=0x7F, ch_r1=0x80 -> left 0x0080, right 0xFF80.
- Change ch_r0 from 0x80 to 0xC0 mid-left-slot -> current frame right slot is still 0x0000; the next frame right slot is 0x2000.
- en=0 with non-silent channels -> all slots 0 from the next capture; bclk, lrck and sample_stb keep running. Setting en=1 again restores data at the following capture.
- Assert rst at bit_cnt=40 mid-right-slot -> all outputs 0 immediately. After release, the first capture occurs 8 clk28 cycles later with a full fresh frame.
